// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, taken-branch flushes,
// load-use interlocks and instruction-fetch misses into pipeline enables.
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [7:0]        flush_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic load_use_raw;
    logic load_use;
    logic branch_fire;
    logic stall_sat;
    logic flush_sat;

    // The register right after a stall or flush holds a bubble, so a repeat
    // match against it must not re-trigger the interlock.
    always_comb begin
        load_use_raw = ex_mem_read && (ex_rd != '0) &&
                       ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        load_use     = load_use_raw &&
                       (cur_state != LOAD_STALL) && (cur_state != FLUSH);
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        branch_fire  = 1'b0;
        next_state   = RUN;
        if (reset) begin
            next_state = RUN;
        end else if (!dmem_ready) begin
            next_state = MEM_WAIT;
        end else if (ex_branch_taken) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            branch_fire  = 1'b1;
            next_state   = FLUSH;
        end else if (load_use) begin
            id_ex_bubble = 1'b1;
            next_state   = LOAD_STALL;
        end else if (!imem_ready) begin
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            next_state  = RUN;
        end else begin
            pc_en      = 1'b1;
            if_id_en   = 1'b1;
            next_state = RUN;
        end
    end

    assign stall_sat = &stall_cnt;
    assign flush_sat = &flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= RUN;
            stall_cnt <= '0;
            flush_cnt <= 8'h00;
        end else begin
            cur_state <= next_state;
            if (!pc_en && !stall_sat)
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (branch_fire && !flush_sat)
                flush_cnt <= flush_cnt + 8'h01;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed
// by random traffic, checked against a rule-table reference model.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready, dmem_ready;

    logic        pc_en, if_id_en, if_id_flush, id_ex_bubble;
    logic [15:0] stall_cnt;
    logic [7:0]  flush_cnt;
    logic [1:0]  state;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_bubble;
    logic [3:0]  s_stall_cnt;
    logic [7:0]  s_flush_cnt;
    logic [1:0]  s_state;

    int checks   = 0;
    int failures = 0;
    int item     = 0;

    typedef struct {
        logic [3:0]  act;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [7:0]  fc;
        logic [3:0]  ss;
        int          idx;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: what the registered outputs should hold right now.
    int m_state = 0;
    int m_stall = 0;
    int m_small = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s item=%0d got=%0h exp=%0h", name, idx, got, want);
        end
    endtask

    // Situation kinds, highest priority first: 0 freeze, 1 branch, 2 load-use,
    // 3 fetch miss, 4 normal, 5 reset. Action bits are {pc,ifid_en,flush,bubble}.
    task automatic applyStimulus(input logic rst, input logic dmem, input logic br,
                                 input logic imem, input logic mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u2);
        logic [3:0] act_tab [6];
        int         next_tab [6];
        int         kind;
        bit         hazard;
        exp_t       e;
        act_tab  = '{4'b0000, 4'b1111, 4'b0001, 4'b0110, 4'b1100, 4'b0000};
        next_tab = '{3, 2, 1, 0, 0, 0};
        @(posedge clk);
        #2;
        reset = rst; dmem_ready = dmem; ex_branch_taken = br; imem_ready = imem;
        ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
        if (rst) begin
            m_state = 0; m_stall = 0; m_small = 0; m_flush = 0;
        end
        hazard = mr && (rd != 0) && ((rd == rs1) || (u2 && rd == rs2)) &&
                 !(m_state == 1 || m_state == 2);
        if (rst)        kind = 5;
        else if (!dmem) kind = 0;
        else if (br)    kind = 1;
        else if (hazard) kind = 2;
        else if (!imem) kind = 3;
        else            kind = 4;
        e.act = act_tab[kind];
        e.st  = 2'(m_state);
        e.sc  = 16'(m_stall);
        e.fc  = 8'(m_flush);
        e.ss  = 4'(m_small);
        e.idx = item++;
        exp_q.push_back(e);
        if (!rst) begin
            m_state = next_tab[kind];
            if (!act_tab[kind][3]) begin
                if (m_stall < 65535) m_stall++;
                if (m_small < 15)    m_small++;
            end
            if (kind == 1 && m_flush < 255) m_flush++;
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, well away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc_en",        e.idx, 32'(pc_en),        32'(e.act[3]));
                checkOutput("if_id_en",     e.idx, 32'(if_id_en),     32'(e.act[2]));
                checkOutput("if_id_flush",  e.idx, 32'(if_id_flush),  32'(e.act[1]));
                checkOutput("id_ex_bubble", e.idx, 32'(id_ex_bubble), 32'(e.act[0]));
                checkOutput("state",        e.idx, 32'(state),        32'(e.st));
                checkOutput("stall_cnt",    e.idx, 32'(stall_cnt),    32'(e.sc));
                checkOutput("flush_cnt",    e.idx, 32'(flush_cnt),    32'(e.fc));
                checkOutput("stall_cnt_w4", e.idx, 32'(s_stall_cnt),  32'(e.ss));
            end
        end
    end

    initial begin
        int wait_cycles;
        reset = 1'b1; dmem_ready = 1'b1; ex_branch_taken = 1'b0; imem_ready = 1'b1;
        ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;

        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        // load-use on rs1, then release
        applyStimulus(0, 1, 0, 1, 1, 5, 5, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 5, 5, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        // x0 never interlocks; rs2 only matters when it is read
        applyStimulus(0, 1, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 1, 7, 1, 7, 0);
        applyStimulus(0, 1, 0, 1, 1, 7, 1, 7, 1);
        applyStimulus(0, 1, 0, 1, 1, 7, 1, 7, 1);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        // branch collides with load-use
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1, 5, 5, 0, 0);
        applyStimulus(0, 1, 0, 1, 1, 5, 5, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        // memory wait holds a pending branch for three cycles
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        // fetch misses, then drive the narrow counter into saturation
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);
        repeat (16) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        // reset lands in the middle of a memory wait
        repeat (2) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        // random traffic with a small register space so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(0,
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) != 0),
                          ($urandom_range(0, 1) == 1),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1));
        end
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        checkOutput("queue_drained", item, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
